// File: rtl/msx_vram_arbiter.sv
// Time-slot arbiter for the two single-port VRAM banks: the VDP owns every ce_10m7_p cycle,
// and the free cycles in between go to the clear engine or the host port.
module msx_vram_arbiter #(
    parameter int          ADDR_W    = 16,
    parameter logic [7:0]  CLR_VALUE = 8'h00
) (
    input  logic              clk21m,
    input  logic              reset,
    input  logic              ce_10m7_p,
    input  logic              msx1,
    input  logic [ADDR_W-1:0] vdp_addr,
    input  logic [7:0]        vdp_do,
    input  logic              vdp_we_lo,
    input  logic              vdp_we_hi,
    output logic [7:0]        vdp_di_lo,
    output logic [7:0]        vdp_di_hi,
    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_bank,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic [7:0]        host_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_do,
    output logic              ram_we_lo,
    output logic              ram_we_hi,
    input  logic [7:0]        ram_di_lo,
    input  logic [7:0]        ram_di_hi
);

    // The host access cycle is the free slot in which IDLE grants; it needs no state of its own,
    // so a read moves straight to CAPTURE and a write straight to ACK.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t            state;
    logic              vdp_slot_d;
    logic [ADDR_W-1:0] clr_cnt;
    logic              host_bank_q;
    logic              grant;

    assign grant = ~reset & ~ce_10m7_p & ~clr_busy & host_req & (state == IDLE);

    always_comb begin
        ram_addr  = vdp_addr;
        ram_do    = vdp_do;
        ram_we_lo = 1'b0;
        ram_we_hi = 1'b0;
        if (reset) begin
            ram_addr = '0;
            ram_do   = '0;
        end else if (ce_10m7_p) begin
            ram_we_lo = vdp_we_lo;
            ram_we_hi = vdp_we_hi & ~msx1;
        end else if (clr_busy) begin
            // The clear fills the hi bank even on MSX1 so a later MSX2 boot sees clean VRAM.
            ram_addr  = clr_cnt;
            ram_do    = CLR_VALUE;
            ram_we_lo = 1'b1;
            ram_we_hi = 1'b1;
        end else if (grant) begin
            ram_addr  = host_addr;
            ram_do    = host_wdata;
            ram_we_lo = host_we & ~host_bank;
            ram_we_hi = host_we &  host_bank;
        end
    end

    always_ff @(posedge clk21m) begin
        if (reset) begin
            vdp_slot_d  <= 1'b0;
            vdp_di_lo   <= 8'h00;
            vdp_di_hi   <= 8'h00;
            clr_busy    <= 1'b0;
            clr_cnt     <= '0;
            state       <= IDLE;
            host_bank_q <= 1'b0;
            host_ack    <= 1'b0;
            host_rdata  <= 8'h00;
        end else begin
            // RAM q lags the address by one cycle, so capture one cycle after a VDP slot.
            vdp_slot_d <= ce_10m7_p;
            if (vdp_slot_d) begin
                vdp_di_lo <= ram_di_lo;
                vdp_di_hi <= ram_di_hi;
            end

            if (!clr_busy) begin
                if (clr_start) begin
                    clr_busy <= 1'b1;
                    clr_cnt  <= '0;
                end
            end else if (!ce_10m7_p) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (clr_cnt == '1) begin
                    clr_busy <= 1'b0;
                end
            end

            host_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        host_bank_q <= host_bank;
                        if (host_we) begin
                            state    <= ACK;
                            host_ack <= 1'b1;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    host_rdata <= host_bank_q ? ram_di_hi : ram_di_lo;
                    state      <= ACK;
                    host_ack   <= 1'b1;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msx_vram_arbiter.sv
// Directed bench for msx_vram_arbiter with a behavioural model of the two VRAM banks.
module tb_msx_vram_arbiter;

    logic        clk21m;
    logic        reset;
    logic        ce_10m7_p;
    logic        msx1;
    logic [15:0] vdp_addr;
    logic [7:0]  vdp_do;
    logic        vdp_we_lo;
    logic        vdp_we_hi;
    logic [7:0]  vdp_di_lo;
    logic [7:0]  vdp_di_hi;
    logic        host_req;
    logic        host_we;
    logic        host_bank;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        clr_start;
    logic        clr_busy;
    logic [15:0] ram_addr;
    logic [7:0]  ram_do;
    logic        ram_we_lo;
    logic        ram_we_hi;
    logic [7:0]  ram_di_lo;
    logic [7:0]  ram_di_hi;

    logic [7:0] mem_lo [0:65535];
    logic [7:0] mem_hi [0:65535];

    int   total = 0;
    int   bad   = 0;
    int   ce_mode = 0;          // 0 alternate, 1 hold high, 2 hold low
    logic vdp_watch = 1'b0;
    logic [7:0] vdp_exp = 8'h00;
    logic vdp_glitch;
    logic seen_we_lo;
    logic seen_we_hi;

    msx_vram_arbiter #(.ADDR_W(16), .CLR_VALUE(8'h00)) dut (
        .clk21m(clk21m), .reset(reset), .ce_10m7_p(ce_10m7_p), .msx1(msx1),
        .vdp_addr(vdp_addr), .vdp_do(vdp_do), .vdp_we_lo(vdp_we_lo), .vdp_we_hi(vdp_we_hi),
        .vdp_di_lo(vdp_di_lo), .vdp_di_hi(vdp_di_hi),
        .host_req(host_req), .host_we(host_we), .host_bank(host_bank), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .ram_addr(ram_addr), .ram_do(ram_do), .ram_we_lo(ram_we_lo), .ram_we_hi(ram_we_hi),
        .ram_di_lo(ram_di_lo), .ram_di_hi(ram_di_hi)
    );

    initial clk21m = 1'b0;
    always #5 clk21m = ~clk21m;

    // Registered-read single-port banks: q shows the old contents of the addressed byte.
    always @(posedge clk21m) begin
        ram_di_lo <= mem_lo[ram_addr];
        ram_di_hi <= mem_hi[ram_addr];
        if (ram_we_lo === 1'b1) mem_lo[ram_addr] = ram_do;
        if (ram_we_hi === 1'b1) mem_hi[ram_addr] = ram_do;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk21m);
        #1;
        case (ce_mode)
            0:       ce_10m7_p = ~ce_10m7_p;
            1:       ce_10m7_p = 1'b1;
            default: ce_10m7_p = 1'b0;
        endcase
    endtask

    task automatic to_ce(input logic v);
        for (int i = 0; i < 3; i++) begin
            if (ce_10m7_p === v) break;
            tick();
        end
    endtask

    task automatic host_txn(input logic we, input logic bank, input logic [15:0] addr,
                            input logic [7:0] wd, input int budget,
                            output logic [7:0] rd, output int lat, output int acks);
        host_req = 1'b1; host_we = we; host_bank = bank; host_addr = addr; host_wdata = wd;
        seen_we_lo = 1'b0; seen_we_hi = 1'b0; vdp_glitch = 1'b0;
        rd = 8'hxx; lat = -1; acks = 0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (ram_we_lo === 1'b1) seen_we_lo = 1'b1;
            if (ram_we_hi === 1'b1) seen_we_hi = 1'b1;
            if (vdp_watch && vdp_di_lo !== vdp_exp) vdp_glitch = 1'b1;
            if (host_ack === 1'b1) begin
                acks++; rd = host_rdata; lat = i; host_req = 1'b0;
                break;
            end
            tick();
        end
        host_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            if (host_ack === 1'b1) acks++;
            if (vdp_watch && vdp_di_lo !== vdp_exp) vdp_glitch = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] exp6 [0:3];
        int lat, acks, k, n_free, cyc;
        logic we_bad, ack_busy, vdp_wrote;

        for (int i = 0; i < 65536; i++) begin
            mem_lo[i] = i[7:0] ^ 8'hC3;
            mem_hi[i] = i[7:0] ^ 8'h3C;
        end
        mem_lo[16'h1234] = 8'hA5; mem_hi[16'h1234] = 8'h5A;
        mem_lo[0] = 8'h10; mem_lo[1] = 8'h21; mem_lo[2] = 8'h32; mem_lo[3] = 8'h43;
        mem_lo[16'hFFFF] = 8'h77; mem_hi[0] = 8'h66;
        exp6[0] = 8'h10; exp6[1] = 8'h21; exp6[2] = 8'h32; exp6[3] = 8'h43;

        reset = 1'b1; ce_10m7_p = 1'b0; msx1 = 1'b0;
        vdp_addr = 16'h1234; vdp_do = 8'h00; vdp_we_lo = 1'b0; vdp_we_hi = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_bank = 1'b0; host_addr = 16'h0000; host_wdata = 8'h00;
        clr_start = 1'b0;

        // Reset state
        tick(); tick(); tick(); #1;
        check("rst_host_ack", host_ack, 0);
        check("rst_clr_busy", clr_busy, 0);
        check("rst_vdp_di_lo", vdp_di_lo, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_ram_we_lo", ram_we_lo, 0);
        reset = 1'b0;

        // 1: VDP keeps reading lo/hi 0x1234 while the host reads in free slots
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("t1_vdp_lo_init", vdp_di_lo, 8'hA5);
        check("t1_vdp_hi_init", vdp_di_hi, 8'h5A);
        vdp_watch = 1'b1; vdp_exp = 8'hA5;
        host_txn(1'b0, 1'b1, 16'h1234, 8'h00, 12, rd, lat, acks);
        check("t1_host_rdata", rd, 8'h5A);
        check("t1_ack_count", acks, 1);
        check("t1_vdp_stable", vdp_glitch, 0);
        host_txn(1'b0, 1'b1, 16'h0010, 8'h00, 12, rd, lat, acks);
        check("t1_host_rdata_other", rd, 8'h2C);
        check("t1_vdp_stable_other", vdp_glitch, 0);
        check("t1_vdp_hi_kept", vdp_di_hi, 8'h5A);
        vdp_watch = 1'b0;

        // 2: host write to hi bank on MSX1; VDP hi writes suppressed
        msx1 = 1'b1;
        to_ce(1'b0);
        host_txn(1'b1, 1'b1, 16'h0100, 8'h3C, 12, rd, lat, acks);
        check("t2_wr_ack_count", acks, 1);
        check("t2_wr_latency", lat, 1);
        check("t2_we_hi_seen", seen_we_hi, 1);
        check("t2_we_lo_seen", seen_we_lo, 0);
        to_ce(1'b1);
        vdp_addr = 16'h0100; vdp_do = 8'hFF; vdp_we_hi = 1'b1; #1;
        check("t2_msx1_we_hi", ram_we_hi, 0);
        tick(); vdp_we_hi = 1'b0;
        host_txn(1'b0, 1'b1, 16'h0100, 8'h00, 12, rd, lat, acks);
        check("t2_readback", rd, 8'h3C);
        msx1 = 1'b0;
        to_ce(1'b1);
        vdp_do = 8'h99; vdp_we_hi = 1'b1; #1;
        check("t2_msx2_we_hi", ram_we_hi, 1);
        tick(); vdp_we_hi = 1'b0;
        host_txn(1'b0, 1'b1, 16'h0100, 8'h00, 12, rd, lat, acks);
        check("t2_readback_msx2", rd, 8'h99);
        to_ce(1'b0);
        vdp_addr = 16'h0200; vdp_we_lo = 1'b1; #1;
        check("t2_free_slot_vdp_we", ram_we_lo, 0);
        vdp_we_lo = 1'b0; vdp_addr = 16'h1234;

        // 4: ce stuck high starves the host; first low cycle grants
        ce_mode = 1;
        tick();
        host_req = 1'b1; host_we = 1'b0; host_bank = 1'b0; host_addr = 16'h1234;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (host_ack === 1'b1) acks++;
            tick();
        end
        check("t4_starved_acks", acks, 0);
        ce_mode = 0;
        tick(); #1;
        for (k = 0; k < 8; k++) begin
            if (host_ack === 1'b1) break;
            tick(); #1;
        end
        host_req = 1'b0;
        check("t4_resume_latency", k, 2);
        check("t4_resume_rdata", host_rdata, 8'hA5);

        // 5: reset during CAPTURE drops the read
        to_ce(1'b0);
        host_req = 1'b1; host_we = 1'b0; host_bank = 1'b0; host_addr = 16'h0001;
        #1;
        tick();
        host_req = 1'b0; reset = 1'b1; #1;
        check("t5_rst_ram_we_lo", ram_we_lo, 0);
        check("t5_rst_ram_addr", ram_addr, 0);
        tick();
        reset = 1'b0; #1;
        check("t5_host_ack", host_ack, 0);
        check("t5_host_rdata", host_rdata, 0);
        check("t5_vdp_di_lo", vdp_di_lo, 0);
        check("t5_vdp_di_hi", vdp_di_hi, 0);
        check("t5_clr_busy", clr_busy, 0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            if (host_ack === 1'b1) acks++;
        end
        check("t5_no_late_ack", acks, 0);
        to_ce(1'b0);
        host_txn(1'b0, 1'b0, 16'h0001, 8'h00, 12, rd, lat, acks);
        check("t5_after_rst_rdata", rd, 8'h21);
        check("t5_after_rst_latency", lat, 2);

        // 6: back-to-back reads with host_req held high
        to_ce(1'b0);
        host_req = 1'b1; host_we = 1'b0; host_bank = 1'b0; host_addr = 16'h0000;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            #1;
            if (host_ack === 1'b1) begin
                check($sformatf("t6_rdata_%0d", k), host_rdata, exp6[k]);
                k++;
                if (k == 4) host_req = 1'b0;
                else host_addr = 16'(k);
            end
            tick();
        end
        host_req = 1'b0;
        check("t6_ack_count", k, 4);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (host_ack === 1'b1) acks++;
            tick();
        end
        check("t6_no_extra_ack", acks, 0);

        // 3: full clear, host waits, VDP write still lands
        msx1 = 1'b1;
        to_ce(1'b0);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0; #1;
        check("t3_clr_busy_set", clr_busy, 1);
        n_free = 0; cyc = 0; we_bad = 1'b0; ack_busy = 1'b0; vdp_wrote = 1'b0;
        while (clr_busy === 1'b1 && cyc < 140000) begin
            if (ce_10m7_p === 1'b0) begin
                n_free++;
                if (ram_we_lo !== 1'b1 || ram_we_hi !== 1'b1 || ram_do !== 8'h00) we_bad = 1'b1;
            end
            if (host_ack === 1'b1) ack_busy = 1'b1;
            if (cyc == 10) begin
                host_req = 1'b1; host_we = 1'b0; host_bank = 1'b0; host_addr = 16'hFFFF;
            end
            if (cyc == 20) clr_start = 1'b1;
            if (cyc == 21) clr_start = 1'b0;
            if (cyc >= 30 && cyc < 40 && ce_10m7_p === 1'b1 && !vdp_wrote) begin
                vdp_addr = 16'h0007; vdp_do = 8'hEE; vdp_we_lo = 1'b1; #1;
                check("t3_vdp_we_in_clear", ram_we_lo, 1);
                check("t3_vdp_addr_in_clear", ram_addr, 16'h0007);
                vdp_wrote = 1'b1;
            end else begin
                vdp_we_lo = 1'b0;
            end
            if (cyc == 40) ce_mode = 2;
            tick(); #1;
            cyc++;
        end
        vdp_we_lo = 1'b0;
        check("t3_busy_free_slots", n_free, 65536);
        check("t3_clear_writes", we_bad, 0);
        check("t3_no_ack_while_busy", ack_busy, 0);
        check("t3_mem_lo_8000", mem_lo[16'h8000], 8'h00);
        check("t3_vdp_write_kept", mem_lo[16'h0007], 8'hEE);
        for (k = 0; k < 10; k++) begin
            if (host_ack === 1'b1) break;
            tick(); #1;
        end
        host_req = 1'b0;
        check("t3_host_ack_after_clear", k, 2);
        check("t3_lo_ffff", host_rdata, 8'h00);
        ce_mode = 0;
        tick();
        to_ce(1'b0);
        host_txn(1'b0, 1'b1, 16'h0000, 8'h00, 12, rd, lat, acks);
        check("t3_hi_0000", rd, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
